// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake in, instruction memory write port out.
// The loader side is the master of the memory port and the sink of the stream.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  modport master (input in_data, in_valid, output in_ready, WE, A, WD);
  modport slave  (output in_data, in_valid, input in_ready, WE, A, WD);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader assembling a length-prefixed little-endian byte
// stream into 32-bit instruction memory writes, holding the CPU in reset until done.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  imem_loader_if.master     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              cpu_rst_n_o,
  output logic [15:0]       words_written_o
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] ww_q, ww_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        fire;
  logic        restart;
  logic [15:0] full_len;
  assign fire     = bus.in_valid && bus.in_ready;
  assign restart  = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign full_len = {bus.in_data, len_q[7:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      ww_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ww_q    <= ww_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ww_d    = ww_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (restart) begin
      state_d = LEN0;
      ww_d    = '0;
    end else begin
      case (state_q)
        LEN0: if (fire) begin
          len_d[7:0] = bus.in_data;
          state_d    = LEN1;
        end
        LEN1: if (fire) begin
          len_d[15:8] = bus.in_data;
          idx_d       = '0;
          state_d     = (full_len == 16'd0) ? DONE :
                        ({16'd0, full_len} > 32'(DEPTH)) ? ERR : DATA;
        end
        DATA: if (fire) begin
          word_d[8*idx_q +: 8] = bus.in_data;
          idx_d                = idx_q + 2'd1;
          state_d              = (idx_q == 2'd3) ? WRITE : DATA;
        end
        WRITE: begin
          ww_d    = ww_q + 16'd1;
          state_d = (ww_q + 16'd1 == len_q) ? DONE : DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end
  // Every output decodes from registered state only.
  always_comb begin
    bus.in_ready    = state_q == LEN0 || state_q == LEN1 || state_q == DATA;
    bus.WE          = state_q == WRITE;
    bus.A           = {14'd0, ww_q, 2'b00};
    bus.WD          = word_q;
    busy_o          = bus.in_ready || state_q == WRITE;
    done_o          = state_q == DONE;
    error_o         = state_q == ERR;
    cpu_rst_n_o     = state_q == DONE;
    words_written_o = ww_q;
  end
endmodule
